exp_arbiter: RTL and testbench
==============================

EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one exponential unit.
REQ-002 The block SHALL have parameter TAG_W, default 2, giving the requester-index width (log2 NUM_REQ).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_data  input  NUM_REQ*16  per-requester fp16 operand; requester i occupies bits [16i+15:16i].
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe (combinational).
REQ-008 exp_a  output  16  operand driven to the shared combinational exponential unit.
REQ-009 exp_z  input  16  fp16 result returned by the exponential unit in the same cycle.
REQ-010 exp_status  input  8  status flags returned by the exponential unit (bit1 infinity, bit2 invalid, bit4 huge).
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  16  registered fp16 result.
REQ-014 out_tag  output  TAG_W  index of the requester that owns out_data.
REQ-015 out_status  output  8  registered exp_status belonging to out_data.
REQ-016 err_sticky  output  3  sticky {huge, invalid, infinity} flags.
REQ-017 err_clr  input  1  synchronous clear of err_sticky.
REQ-018 op_count  output  16  count of completed grants, wrapping.

Function
REQ-019 The block SHALL define slot_free = !out_valid | out_ready; no grant SHALL occur when slot_free is 0.
REQ-020 The arbiter SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ, and the first requester with req_valid high wins.
REQ-021 req_ready SHALL be one-hot on the winner when slot_free is 1 and any req_valid is high, and all-zero otherwise; it SHALL never depend on req_valid of other requesters beyond the arbitration.
REQ-022 exp_a SHALL equal the winner's req_data during a grant cycle and 16'h0000 otherwise.
REQ-023 On a grant, the block SHALL register exp_z, exp_status and the winner index into out_data, out_status and out_tag, and SHALL set out_valid at the next edge (latency 1 cycle).
REQ-024 With no grant, out_valid SHALL clear when out_ready is 1 and hold otherwise; out_data, out_tag and out_status SHALL hold while out_valid=1 and out_ready=0.
REQ-025 A grant and an output handshake in the same cycle SHALL replace the result with no bubble, sustaining one result per cycle.
REQ-026 last_grant SHALL update only on a grant; idle cycles SHALL not move the pointer.
REQ-027 err_sticky SHALL OR in {exp_status[4], exp_status[2], exp_status[1]} on every grant and clear on err_clr; when set and clear coincide, set SHALL win.
REQ-028 op_count SHALL increment by 1 per grant and wrap from 16'hFFFF to 16'h0000.
REQ-029 A requester that deasserts req_valid without a handshake SHALL lose nothing; arbitration SHALL re-evaluate every cycle.

Reset
REQ-030 While rst_n=0: out_valid=0, out_data=0, out_tag=0, out_status=0, err_sticky=0, op_count=0, last_grant=NUM_REQ-1 (requester 0 has first priority), req_ready=0.
REQ-031 A reset asserted mid-operation SHALL discard any held result without emitting it.

Verification
REQ-032 Exp-unit stub exp_z=a+1; requester 2 sends 16'h3C00 with out_ready=1 -> next cycle out_valid=1, out_data=16'h3C01, out_tag=2, op_count=1.
REQ-033 All four requesters valid continuously with out_ready=1 -> grant order 0,1,2,3,0,1; one result per cycle; no requester granted twice before the others.
REQ-034 out_valid=1 and out_ready held 0 for 3 cycles with requests pending -> req_ready=0, out_data stable; on release, result handshakes and next grant occurs in the same cycle.
REQ-035 exp_status=8'h04 on a grant together with err_clr=1 -> err_sticky=3'b010 after the edge; err_clr alone next cycle -> 3'b000.
REQ-036 Preload 65535 grants -> op_count=16'hFFFF; one more grant -> 16'h0000.
REQ-037 Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately, no result emitted; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/exp_arbiter.sv
// Round-robin arbiter sharing one combinational fp16 exponential unit among
// NUM_REQ requesters, with a one-deep registered result stage, sticky flags and a grant counter.
module exp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*16-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [15:0]             exp_a,
  input  logic [15:0]             exp_z,
  input  logic [7:0]              exp_status,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [7:0]              out_status,
  output logic [2:0]              err_sticky,
  input  logic                    err_clr,
  output logic [15:0]             op_count
);

  logic [TAG_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       status_q, status_d;
  logic [2:0]       err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [TAG_W-1:0] win_s;
  logic             found_s;
  logic             slot_free_s;
  logic             grant_s;
  int               idx_s;
  logic             hit_s;

  assign slot_free_s = !valid_q || out_ready;

  // Rotating priority search starting one past the last granted requester.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s   = ((int'(last_q) + k) >= NUM_REQ) ? (int'(last_q) + k - NUM_REQ)
                                                 : (int'(last_q) + k);
      hit_s   = !found_s && req_valid[TAG_W'(idx_s)];
      win_s   = hit_s ? TAG_W'(idx_s) : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Reset gates the grant so no requester is accepted while rst_n is low.
  assign grant_s   = rst_n && slot_free_s && found_s;
  assign req_ready = grant_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_s) : {NUM_REQ{1'b0}};
  assign exp_a     = grant_s ? req_data[{win_s, 4'b0000} +: 16] : 16'h0000;

  // Next-state for the result stage, pointer, flags and counter.
  always_comb begin
    last_d   = grant_s ? win_s : last_q;
    valid_d  = grant_s ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d   = grant_s ? exp_z : data_q;
    tag_d    = grant_s ? win_s : tag_q;
    status_d = grant_s ? exp_status : status_q;
    cnt_d    = grant_s ? (cnt_q + 16'd1) : cnt_q;
    // Set has priority over a coincident clear.
    err_d    = (err_clr ? 3'b000 : err_q)
             | (grant_s ? {exp_status[4], exp_status[2], exp_status[1]} : 3'b000);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= TAG_W'(NUM_REQ - 1);
      valid_q  <= 1'b0;
      data_q   <= 16'h0000;
      tag_q    <= '0;
      status_q <= 8'h00;
      err_q    <= 3'b000;
      cnt_q    <= 16'h0000;
    end else begin
      last_q   <= last_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      status_q <= status_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_tag    = tag_q;
  assign out_status = status_q;
  assign err_sticky = err_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Scoreboard bench for exp_arbiter: directed stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_exp_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] exp_a;
  logic [15:0] exp_z;
  logic [7:0]  exp_status;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic [7:0]  out_status;
  logic [2:0]  err_sticky;
  logic        err_clr;
  logic [15:0] op_count;
  logic        mon_en;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  t;
    logic [7:0]  s;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  exp_arbiter #(.NUM_REQ(4), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .exp_a(exp_a), .exp_z(exp_z), .exp_status(exp_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_status(out_status), .err_sticky(err_sticky),
    .err_clr(err_clr), .op_count(op_count)
  );

  // Exponential-unit stub: z = a + 1.
  assign exp_z = exp_a + 16'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] t, input logic [7:0] s);
    exp_t e;
    e.d = d; e.t = t; e.s = s;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every presented-and-accepted result against the queue head.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(out_tag), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data",   32'(out_data),   32'(e.d));
        chk("out_tag",    32'(out_tag),    32'(e.t));
        chk("out_status", 32'(out_status), 32'(e.s));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  order [6];
    logic [15:0] dval  [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    dval  = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    n_chk = 0; n_fail = 0; mon_en = 1'b1;
    rst_n = 1'b0; req_valid = 4'hF; req_data = 64'h0; out_ready = 1'b0;
    err_clr = 1'b0; exp_status = 8'h00;

    // Reset state, with every requester asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_out_tag",    32'(out_tag),    32'd0);
    chk("rst_out_status", 32'(out_status), 32'd0);
    chk("rst_err",        32'(err_sticky), 32'd0);
    chk("rst_op_count",   32'(op_count),   32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);

    // Single request from requester 2.
    cyc();
    rst_n = 1'b1; req_valid = 4'b0100; req_data[47:32] = 16'h3C00; out_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_exp_a", 32'(exp_a), 32'h3C00);
    push(16'h3C01, 2'd2, 8'h00);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_op_count", 32'(op_count), 32'd1);

    // Round-robin with all requesters valid.
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = dval[i];
    req_valid = 4'hF; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << order[n]));
      push(dval[order[n]] + 16'd1, order[n], 8'h00);
      cyc();
    end
    req_valid = 4'b0000;
    @(negedge clk);

    // Backpressure: held result, no grants, then same-cycle replace.
    cyc();
    req_valid = 4'hF;
    @(negedge clk);
    chk("bp_first_ready", 32'(req_ready), 32'h4);
    push(16'h3001, 2'd2, 8'h00);
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
      chk("bp_data_stable", 32'(out_data), 32'h3001);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    push(16'h4001, 2'd3, 8'h00);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);

    // Sticky flags: set beats clear, then clear alone, then other bits.
    cyc();
    req_valid = 4'b0001; exp_status = 8'h04; err_clr = 1'b1;
    @(negedge clk);
    push(16'h1001, 2'd0, 8'h04);
    cyc();
    req_valid = 4'b0000; exp_status = 8'h00;
    @(negedge clk);
    chk("err_set_wins", 32'(err_sticky), 32'h2);
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_sticky), 32'h0);
    cyc();
    req_valid = 4'b0010; exp_status = 8'h12;
    @(negedge clk);
    push(16'h2001, 2'd1, 8'h12);
    cyc();
    req_valid = 4'b0000; exp_status = 8'h00;
    @(negedge clk);
    chk("err_huge_inf", 32'(err_sticky), 32'h5);

    // Counter wrap after 65535 grants.
    cyc();
    mon_en = 1'b0;
    do_reset();
    req_valid = 4'hF;
    repeat (65535) @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("cnt_ffff", 32'(op_count), 32'hFFFF);
    cyc();
    mon_en = 1'b1; req_valid = 4'hF;
    @(negedge clk);
    chk("cnt_wrap_ready", 32'(req_ready), 32'h8);
    push(16'h4001, 2'd3, 8'h00);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("cnt_wrap", 32'(op_count), 32'h0);

    // Reset while a result is held: discarded, priority back to requester 0.
    cyc();
    out_ready = 1'b0; req_valid = 4'b0010;
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("held_before_rst", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_data",  32'(out_data),  32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    cyc();
    rst_n = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    push(16'h1001, 2'd0, 8'h00);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    cyc();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
